// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS main controller: opcode and funct
// values, 4-bit state encodings, control-field codes and the control-word struct.
package mc_pkg;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // Funct values (IR[5:0])
    localparam logic [5:0] FUNCT_JR = 6'b001000;

    // ALUOp codes
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALUSrcB codes
    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // RegDst codes
    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    // MemtoReg codes
    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    // PCSource codes
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_REG    = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IEXEC  = 4'd10,
        S_IWB    = 4'd11,
        S_JAL    = 4'd12,
        S_JR     = 4'd13
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mdr_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } ctrl_t;

    // True for every opcode DECODE knows how to dispatch
    function automatic logic is_known_op(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_JAL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath bus: instruction fields and memory handshake in,
// control strobes and selects out. master = controller, slave = datapath.
interface mc_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mdr_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;

    modport master (
        input  op, funct, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mdr_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               alu_op, pc_source, illegal_op
    );

    modport slave (
        output op, funct, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mdr_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               alu_op, pc_source, illegal_op
    );
endinterface

// File: rtl/mc_ctrl_outdec.sv
// Combinational state -> control-word decoder for the multicycle controller.
// Optional MC_CTRL_JR_EN adds the JR state decode (pc_source = A).
module mc_ctrl_outdec
    import mc_pkg::*;
(
    input  state_t     state,
    input  logic       mem_ready,
    input  logic [5:0] op,
    output ctrl_t      ctrl
);

    // Moore decode; only the FETCH/MEMRD load strobes wait on mem_ready
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.i_or_d    = 1'b0;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                // Branch target computed speculatively into ALUOut
                ctrl.alu_src_a  = 1'b0;
                ctrl.alu_src_b  = SRCB_IMM_SH;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.illegal_op = ~is_known_op(op);
            end
            S_MEMADR, S_IEXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_read  = 1'b1;
                ctrl.i_or_d    = 1'b1;
                ctrl.mdr_write = mem_ready;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = REGDST_RT;
                ctrl.mem_to_reg = M2R_MDR;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_RWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = REGDST_RD;
                ctrl.mem_to_reg = M2R_ALUOUT;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            S_IWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = REGDST_RT;
                ctrl.mem_to_reg = M2R_ALUOUT;
            end
            S_JAL: begin
                // PC already holds PC+4 from FETCH, so it is the link value
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = REGDST_RA;
                ctrl.mem_to_reg = M2R_PC;
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCSRC_JUMP;
            end
`ifdef MC_CTRL_JR_EN
            S_JR: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_REG;
            end
`endif
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Main control FSM of the multicycle MIPS core with retired-instruction counter.
// Optional feature macro: MC_CTRL_JR_EN (dedicated jr state, pc_source = A).
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    mc_ctrl_if.master        bus,
    output logic [CNT_W-1:0] instr_count
);

    state_t state;
    ctrl_t  ctrl_dec;
    ctrl_t  ctrl_out;

    mc_ctrl_outdec u_outdec (
        .state     (state),
        .mem_ready (bus.mem_ready),
        .op        (bus.op),
        .ctrl      (ctrl_dec)
    );

`ifndef MC_CTRL_JR_EN
    // funct only matters for the jr dispatch
    logic unused_funct;
    assign unused_funct = ^bus.funct;
`endif

    // State register, next-state dispatch and retire counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_FETCH;
            instr_count <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (bus.mem_ready) state <= S_DECODE;
                end
                S_DECODE: begin
                    case (bus.op)
                        OP_LW, OP_SW: state <= S_MEMADR;
                        OP_RTYPE: begin
`ifdef MC_CTRL_JR_EN
                            if (bus.funct == FUNCT_JR) state <= S_JR;
                            else                       state <= S_EXEC;
`else
                            state <= S_EXEC;
`endif
                        end
                        OP_BEQ:  state <= S_BRANCH;
                        OP_J:    state <= S_JUMP;
                        OP_ADDI: state <= S_IEXEC;
                        OP_JAL:  state <= S_JAL;
                        // undecoded op: back to FETCH without retiring
                        default: state <= S_FETCH;
                    endcase
                end
                S_MEMADR: state <= (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD: begin
                    if (bus.mem_ready) state <= S_MEMWB;
                end
                S_MEMWR: begin
                    if (bus.mem_ready) begin
                        state       <= S_FETCH;
                        instr_count <= instr_count + CNT_W'(1);
                    end
                end
                S_EXEC:  state <= S_RWB;
                S_IEXEC: state <= S_IWB;
                S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_IWB, S_JAL, S_JR: begin
                    state       <= S_FETCH;
                    instr_count <= instr_count + CNT_W'(1);
                end
                default: state <= S_FETCH;
            endcase
        end
    end

    // Reset forces every control low immediately, independent of the clock
    assign ctrl_out = rst ? '0 : ctrl_dec;

    assign bus.pc_write      = ctrl_out.pc_write;
    assign bus.pc_write_cond = ctrl_out.pc_write_cond;
    assign bus.i_or_d        = ctrl_out.i_or_d;
    assign bus.mem_read      = ctrl_out.mem_read;
    assign bus.mem_write     = ctrl_out.mem_write;
    assign bus.ir_write      = ctrl_out.ir_write;
    assign bus.mdr_write     = ctrl_out.mdr_write;
    assign bus.reg_dst       = ctrl_out.reg_dst;
    assign bus.mem_to_reg    = ctrl_out.mem_to_reg;
    assign bus.reg_write     = ctrl_out.reg_write;
    assign bus.alu_src_a     = ctrl_out.alu_src_a;
    assign bus.alu_src_b     = ctrl_out.alu_src_b;
    assign bus.alu_op        = ctrl_out.alu_op;
    assign bus.pc_source     = ctrl_out.pc_source;
    assign bus.illegal_op    = ctrl_out.illegal_op;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed testbench for mc_ctrl: walks each instruction class cycle by cycle
// and compares the full control word against hand-written per-state vectors.
module tb_mc_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] instr_count;
    int          n_checks;
    int          n_errors;

    mc_ctrl_if bus ();

    mc_ctrl #(.CNT_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word, MSB first:
    // pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mdr_write,
    // reg_dst[2], mem_to_reg[2], reg_write, alu_src_a, alu_src_b[2], alu_op[2],
    // pc_source[2], illegal_op
    logic [19:0] cw;
    assign cw = {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read,
                 bus.mem_write, bus.ir_write, bus.mdr_write, bus.reg_dst,
                 bus.mem_to_reg, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
                 bus.alu_op, bus.pc_source, bus.illegal_op};

    //                                pcw   cond  iord  mrd   mwr   irw   mdr   rdst   m2r    rw    asa   asb    aop    psrc   ill
    localparam logic [19:0] E_ZERO  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [19:0] E_FETCH = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0};
    localparam logic [19:0] E_FSTAL = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0};
    localparam logic [19:0] E_DEC   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0};
    localparam logic [19:0] E_DECIL = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b1};
    localparam logic [19:0] E_MADR  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0};
    localparam logic [19:0] E_MRD   = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [19:0] E_MRDST = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [19:0] E_MWB   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [19:0] E_MWR   = {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [19:0] E_EXEC  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 2'b10, 2'b00, 1'b0};
    localparam logic [19:0] E_RWB   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [19:0] E_BR    = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 2'b01, 2'b01, 1'b0};
    localparam logic [19:0] E_JUMP  = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10, 1'b0};
    localparam logic [19:0] E_IEXEC = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0};
    localparam logic [19:0] E_IWB   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [19:0] E_JAL   = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 1'b1, 1'b0, 2'b00, 2'b00, 2'b10, 1'b0};
    localparam logic [19:0] E_JR    = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b11, 1'b0};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: apply mem_ready, check the control word, advance
    task automatic cyc(input string tag, input logic ready, input logic [19:0] exp);
        bus.mem_ready = ready;
        #1;
        check_val(tag, {12'd0, cw}, {12'd0, exp});
        @(negedge clk);
    endtask

    task automatic set_instr(input logic [5:0] op, input logic [5:0] funct);
        bus.op    = op;
        bus.funct = funct;
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        bus.op        = 6'b100011;
        bus.funct     = 6'b000000;
        bus.mem_ready = 1'b1;

        // Reset held: every control low, counter cleared
        repeat (2) @(negedge clk);
        #1;
        check_val("rst_cw", {12'd0, cw}, 32'd0);
        check_val("rst_cnt", instr_count, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // lw, no stalls: 5 cycles, write-back only in cycle 5
        set_instr(6'b100011, 6'b000000);
        cyc("lw_fetch",  1'b1, E_FETCH);
        cyc("lw_decode", 1'b1, E_DEC);
        cyc("lw_memadr", 1'b1, E_MADR);
        cyc("lw_memrd",  1'b1, E_MRD);
        cyc("lw_memwb",  1'b1, E_MWB);
        check_val("lw_cnt", instr_count, 32'd1);

        // R-type add
        set_instr(6'b000000, 6'b100000);
        cyc("r_fetch",  1'b1, E_FETCH);
        cyc("r_decode", 1'b1, E_DEC);
        cyc("r_exec",   1'b1, E_EXEC);
        cyc("r_rwb",    1'b1, E_RWB);
        check_val("r_cnt", instr_count, 32'd2);

        // sw with three memory stall cycles: mem_write held four cycles
        set_instr(6'b101011, 6'b000000);
        cyc("sw_fetch",  1'b1, E_FETCH);
        cyc("sw_decode", 1'b1, E_DEC);
        cyc("sw_memadr", 1'b1, E_MADR);
        cyc("sw_wr0",    1'b0, E_MWR);
        cyc("sw_wr1",    1'b0, E_MWR);
        check_val("sw_cnt_mid", instr_count, 32'd2);
        cyc("sw_wr2",    1'b0, E_MWR);
        cyc("sw_wr3",    1'b1, E_MWR);
        check_val("sw_cnt", instr_count, 32'd3);

        // beq with two fetch stall cycles: ir_write/pc_write gated by mem_ready
        set_instr(6'b000100, 6'b000000);
        cyc("beq_fstall0", 1'b0, E_FSTAL);
        cyc("beq_fstall1", 1'b0, E_FSTAL);
        cyc("beq_fetch",   1'b1, E_FETCH);
        cyc("beq_decode",  1'b1, E_DEC);
        cyc("beq_branch",  1'b1, E_BR);
        check_val("beq_cnt", instr_count, 32'd4);

        // j
        set_instr(6'b000010, 6'b000000);
        cyc("j_fetch",  1'b1, E_FETCH);
        cyc("j_decode", 1'b1, E_DEC);
        cyc("j_jump",   1'b1, E_JUMP);
        check_val("j_cnt", instr_count, 32'd5);

        // jal
        set_instr(6'b000011, 6'b000000);
        cyc("jal_fetch",  1'b1, E_FETCH);
        cyc("jal_decode", 1'b1, E_DEC);
        cyc("jal_jal",    1'b1, E_JAL);
        check_val("jal_cnt", instr_count, 32'd6);

        // addi
        set_instr(6'b001000, 6'b000000);
        cyc("addi_fetch",  1'b1, E_FETCH);
        cyc("addi_decode", 1'b1, E_DEC);
        cyc("addi_iexec",  1'b1, E_IEXEC);
        cyc("addi_iwb",    1'b1, E_IWB);
        check_val("addi_cnt", instr_count, 32'd7);

        // Undecoded opcode: illegal_op pulse, back to FETCH, not counted
        set_instr(6'b111111, 6'b000000);
        cyc("ill_fetch",  1'b1, E_FETCH);
        cyc("ill_decode", 1'b1, E_DECIL);
        check_val("ill_cnt", instr_count, 32'd7);
        set_instr(6'b000010, 6'b000000);
        cyc("ill_next_fetch", 1'b1, E_FETCH);
        cyc("ill_next_decode", 1'b1, E_DEC);
        cyc("ill_next_jump", 1'b1, E_JUMP);
        check_val("ill_next_cnt", instr_count, 32'd8);

        // jr encoding: dedicated state only when the feature is built in
        set_instr(6'b000000, 6'b001000);
        cyc("jr_fetch",  1'b1, E_FETCH);
        cyc("jr_decode", 1'b1, E_DEC);
`ifdef MC_CTRL_JR_EN
        cyc("jr_jr",     1'b1, E_JR);
`else
        cyc("jr_exec",   1'b1, E_EXEC);
        cyc("jr_rwb",    1'b1, E_RWB);
`endif
        check_val("jr_cnt", instr_count, 32'd9);

        // Reset asserted mid-MEMRD: controls drop at once, restart in FETCH
        set_instr(6'b100011, 6'b000000);
        cyc("rlw_fetch",  1'b1, E_FETCH);
        cyc("rlw_decode", 1'b1, E_DEC);
        cyc("rlw_memadr", 1'b1, E_MADR);
        bus.mem_ready = 1'b0;
        #1;
        check_val("rlw_memrd_stall", {12'd0, cw}, {12'd0, E_MRDST});
        rst = 1'b1;
        #1;
        check_val("rlw_async_cw", {12'd0, cw}, 32'd0);
        check_val("rlw_async_cnt", instr_count, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc("post_rst_fetch",  1'b1, E_FETCH);
        cyc("post_rst_decode", 1'b1, E_DEC);
        cyc("post_rst_memadr", 1'b1, E_MADR);
        cyc("post_rst_memrd",  1'b1, E_MRD);
        cyc("post_rst_memwb",  1'b1, E_MWB);
        check_val("post_rst_cnt", instr_count, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
